// File: rtl/sda_frame_tx_if.sv
// Handshake and line bundle for the scl/sda frame transmitter.
interface sda_frame_tx_if;
  logic [3:0] data;
  logic       valid;
  logic       ready;
  logic       busy;
  logic       done;
  logic       scl;
  logic       sda;

  modport master (
    output data, valid,
    input  ready, busy, done, scl, sda
  );

  modport slave (
    input  data, valid,
    output ready, busy, done, scl, sda
  );
endinterface

// File: rtl/sda_frame_tx.sv
// Serial frame transmitter: start, 4 data bits MSB first, stop slot, stop.
// Every protocol phase lasts CLK_DIV system clocks; all outputs registered.
module sda_frame_tx #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic           clk,
  input  logic           rst,
  sda_frame_tx_if.slave  bus
);

  localparam int unsigned    TW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0]  TICK_LAST = TW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE,
    START,
    B_LOW,
    B_SET,
    B_HIGH,
    P_LOW,
    P_SET,
    P_HIGH,
    STOP
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_tick;
  logic [1:0]    r_bit;
  logic [3:0]    r_shift;
  logic          r_scl;
  logic          r_sda;
  logic          r_ready;
  logic          r_busy;
  logic          r_done;

  logic          w_tick_end;

  assign w_tick_end = (r_tick == TICK_LAST);

  // Line levels are set on entry to each state so they change exactly at the
  // phase boundary, keeping scl and sda edges in separate cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_scl   <= 1'b1;
      r_sda   <= 1'b1;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (bus.valid && r_ready) begin
          r_shift <= bus.data;
          r_bit   <= '0;
          r_tick  <= '0;
          r_state <= START;
          r_scl   <= 1'b1;
          r_sda   <= 1'b0;
          r_ready <= 1'b0;
          r_busy  <= 1'b1;
        end
      end else if (!w_tick_end) begin
        r_tick <= r_tick + 1'b1;
      end else begin
        r_tick <= '0;
        unique case (r_state)
          START: begin
            r_state <= B_LOW;
            r_scl   <= 1'b0;
          end
          B_LOW: begin
            r_state <= B_SET;
            r_sda   <= r_shift[3];
          end
          B_SET: begin
            r_state <= B_HIGH;
            r_scl   <= 1'b1;
          end
          B_HIGH: begin
            r_shift <= {r_shift[2:0], 1'b0};
            r_bit   <= r_bit + 2'd1;
            r_scl   <= 1'b0;
            r_state <= (r_bit == 2'd3) ? P_LOW : B_LOW;
          end
          P_LOW: begin
            r_state <= P_SET;
            r_sda   <= 1'b0;
          end
          P_SET: begin
            r_state <= P_HIGH;
            r_scl   <= 1'b1;
          end
          P_HIGH: begin
            r_state <= STOP;
            r_sda   <= 1'b1;
          end
          STOP: begin
            r_state <= IDLE;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.scl   = r_scl;
  assign bus.sda   = r_sda;
  assign bus.ready = r_ready;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;

endmodule

// File: tb/tb_sda_frame_tx.sv
// Directed bench for sda_frame_tx: two instances (CLK_DIV 4 and 2), a
// scoreboard of expected bits / decoded one-hot, and a line-protocol monitor.
module tb_sda_frame_tx;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sda_frame_tx_if b4 ();
  sda_frame_tx_if b2 ();

  sda_frame_tx #(.CLK_DIV(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
  sda_frame_tx #(.CLK_DIV(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  longint      cyc         = 0;
  longint      last_stop   = -1000;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic get(input bit sel, output logic scl, output logic sda,
                     output logic rdy, output logic bsy, output logic dn);
    if (sel) begin
      scl = b2.scl; sda = b2.sda; rdy = b2.ready; bsy = b2.busy; dn = b2.done;
    end else begin
      scl = b4.scl; sda = b4.sda; rdy = b4.ready; bsy = b4.busy; dn = b4.done;
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic [3:0] d);
    if (sel) begin
      b2.valid = v; b2.data = d;
    end else begin
      b4.valid = v; b4.data = d;
    end
  endtask

  task automatic check_idle(input string tag, input bit sel);
    logic scl, sda, rdy, bsy, dn;
    get(sel, scl, sda, rdy, bsy, dn);
    check({tag, "_scl"}, scl, 1'b1);
    check({tag, "_sda"}, sda, 1'b1);
    check({tag, "_ready"}, rdy, 1'b1);
    check({tag, "_busy"}, bsy, 1'b0);
    check({tag, "_done"}, dn, 1'b0);
  endtask

  // Send one word and follow the frame to its done cycle. hold keeps valid
  // high with alt data during the frame; abort_at >= 0 resets mid-frame;
  // b2b checks bus-free time against the previous stop.
  task automatic send(input bit sel, input logic [3:0] d, input bit hold,
                      input logic [3:0] alt, input int abort_at, input bit b2b);
    int          cd;
    int          w;
    int          rises;
    int          viol;
    logic        scl, sda, rdy, bsy, dn;
    logic        pscl;
    logic        psda;
    logic [3:0]  rx;
    logic [3:0]  idx;
    logic [15:0] expv;
    cd    = sel ? 2 : 4;
    w     = 0;
    rises = 0;
    viol  = 0;
    pscl  = 1'b1;
    psda  = 1'b1;
    rx    = '0;

    get(sel, scl, sda, rdy, bsy, dn);
    while (!rdy && w < 200) begin
      tick();
      get(sel, scl, sda, rdy, bsy, dn);
      w++;
    end
    check("ready_before_accept", rdy, 1'b1);

    drive(sel, 1'b1, d);
    for (int i = 3; i >= 0; i--) exp_q.push_back({15'd0, d[i]});
    idx = d - 4'd1;
    exp_q.push_back(16'd1 << idx);
    tick();
    if (hold) drive(sel, 1'b1, alt);
    else      drive(sel, 1'b0, alt);

    for (int n = 0; n <= 17 * cd; n++) begin
      if (n > 0) tick();
      get(sel, scl, sda, rdy, bsy, dn);

      if (n == 0) begin
        check("start_sda", sda, 1'b0);
        check("start_scl", scl, 1'b1);
        check("start_ready", rdy, 1'b0);
        check("start_busy", bsy, 1'b1);
        if (b2b) check("bus_free", 16'(cyc - last_stop), 16'(cd + 1));
      end

      if (abort_at >= 0 && n == abort_at) begin
        check("abort_in_bhigh_scl", scl, 1'b1);
        rst = 1'b1;
        drive(sel, 1'b0, alt);
        tick();
        check_idle("abort_reset", sel);
        rst = 1'b0;
        exp_q.delete();
        return;
      end

      if (sda !== psda && scl !== pscl) viol++;
      if (sda !== psda && scl && pscl && n != 0 && n != 16 * cd) viol++;

      if (scl && !pscl) begin
        rises++;
        check("rise_time", 16'(n), 16'(3 * cd * rises));
        if (rises <= 4) begin
          rx = {rx[2:0], sda};
          if (exp_q.size() == 0) check("scoreboard_underflow", 16'd0, 16'd1);
          else check("data_bit", {15'd0, sda}, exp_q.pop_front());
        end else begin
          check("stop_slot_sda", sda, 1'b0);
        end
      end

      if (n == 16 * cd - 1) check("pre_stop_sda", sda, 1'b0);
      if (n == 16 * cd) begin
        check("stop_sda", sda, 1'b1);
        check("stop_scl", scl, 1'b1);
        last_stop = cyc;
      end
      if (n == 17 * cd - 1) begin
        check("pre_done", dn, 1'b0);
        check("pre_done_busy", bsy, 1'b1);
      end
      if (n == 17 * cd) begin
        check("done_pulse", dn, 1'b1);
        check("done_ready", rdy, 1'b1);
        check("done_busy", bsy, 1'b0);
        check("done_lines", {scl, sda}, 2'b11);
      end
      pscl = scl;
      psda = sda;
    end

    check("scl_rises", 16'(rises), 16'd5);
    check("line_violations", 16'(viol), 16'd0);
    idx = rx - 4'd1;
    if (exp_q.size() == 0) check("scoreboard_underflow", 16'd0, 16'd1);
    else check("rx_onehot", 16'd1 << idx, exp_q.pop_front());

    if (!hold) begin
      tick();
      get(sel, scl, sda, rdy, bsy, dn);
      check("done_single", dn, 1'b0);
      check("idle_after_done", {scl, sda, rdy, bsy}, 4'b1110);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b1, 4'hF);
    drive(1'b1, 1'b1, 4'hF);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("reset4", 1'b0);
      check_idle("reset2", 1'b1);
    end
    drive(1'b0, 1'b0, 4'h0);
    drive(1'b1, 1'b0, 4'h0);
    rst = 1'b0;
    tick();
    check_idle("post_reset4", 1'b0);
    check_idle("post_reset2", 1'b1);

    send(1'b0, 4'b1010, 1'b0, 4'h0, -1, 1'b0);
    send(1'b0, 4'b0000, 1'b0, 4'h0, -1, 1'b0);
    send(1'b0, 4'b1111, 1'b0, 4'h0, -1, 1'b0);
    send(1'b0, 4'b1100, 1'b1, 4'b0101, -1, 1'b0);
    send(1'b0, 4'b0011, 1'b0, 4'h0, -1, 1'b1);
    send(1'b0, 4'b0110, 1'b0, 4'h0, 25, 1'b0);
    send(1'b0, 4'b1001, 1'b0, 4'h0, -1, 1'b0);
    send(1'b1, 4'b1010, 1'b0, 4'h0, -1, 1'b0);
    send(1'b1, 4'b0101, 1'b0, 4'h0, -1, 1'b0);

    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
